// File: rtl/cdc_hs_bus_sync.sv
// Handshaked single-word bus synchroniser (i_src_clk -> i_dst_clk) using 2-phase request/ack toggles.
// Define CDC_HS_XFER_CNT_EN to build the 16-bit destination transfer counter on o_dst_xfer_cnt.
`timescale 1ns/1ps
module cdc_hs_bus_sync #(
    parameter int DWIDTH      = 32,
    parameter int SYNC_STAGES = 2
) (
    input  logic              i_src_clk,
    input  logic              i_dst_clk,
    input  logic              rst_n,
    input  logic [DWIDTH-1:0] i_src_data,
    input  logic              i_src_valid,
    output logic              o_src_ready,
    output logic [DWIDTH-1:0] o_dst_data,
    output logic              o_dst_valid,
    input  logic              i_dst_ready,
    output logic [15:0]       o_dst_xfer_cnt
);

    generate
        if (SYNC_STAGES < 2) begin : g_bad_sync_stages
            $error("cdc_hs_bus_sync: SYNC_STAGES must be at least 2");
        end
    endgenerate

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } src_state_t;

    // ---------------- source domain ----------------
    src_state_t               state_q, state_d;
    logic                     src_ready_q, src_ready_d;
    logic                     req_tgl_q, req_tgl_d;
    logic [DWIDTH-1:0]        hold_q, hold_d;
    logic [SYNC_STAGES-1:0]   ack_sync_q, ack_sync_d;
    logic                     ack_prev_q, ack_prev_d;
    logic                     ack_edge;

    // ---------------- destination domain ----------------
    logic [SYNC_STAGES-1:0]   req_sync_q, req_sync_d;
    logic                     req_prev_q, req_prev_d;
    logic                     req_edge;
    logic                     dst_valid_q, dst_valid_d;
    logic [DWIDTH-1:0]        dst_data_q, dst_data_d;
    logic                     ack_tgl_q, ack_tgl_d;
    logic                     dst_take;

    always_comb begin
        ack_sync_d  = {ack_sync_q[SYNC_STAGES-2:0], ack_tgl_q};
        ack_prev_d  = ack_sync_q[SYNC_STAGES-1];
        ack_edge    = ack_sync_q[SYNC_STAGES-1] ^ ack_prev_q;
        state_d     = state_q;
        src_ready_d = src_ready_q;
        req_tgl_d   = req_tgl_q;
        hold_d      = hold_q;
        case (state_q)
            IDLE: begin
                if (i_src_valid) begin
                    hold_d      = i_src_data;
                    req_tgl_d   = ~req_tgl_q;
                    state_d     = BUSY;
                    src_ready_d = 1'b0;
                end
            end
            BUSY: begin
                // Hold register stays frozen until the consumer's ack has come back.
                if (ack_edge) begin
                    state_d     = IDLE;
                    src_ready_d = 1'b1;
                end
            end
            default: begin
                state_d     = IDLE;
                src_ready_d = 1'b1;
            end
        endcase
    end

    always_ff @(posedge i_src_clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            src_ready_q <= 1'b1;
            req_tgl_q   <= 1'b0;
            hold_q      <= '0;
            ack_sync_q  <= '0;
            ack_prev_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            src_ready_q <= src_ready_d;
            req_tgl_q   <= req_tgl_d;
            hold_q      <= hold_d;
            ack_sync_q  <= ack_sync_d;
            ack_prev_q  <= ack_prev_d;
        end
    end

    assign o_src_ready = src_ready_q;

    always_comb begin
        req_sync_d  = {req_sync_q[SYNC_STAGES-2:0], req_tgl_q};
        req_prev_d  = req_sync_q[SYNC_STAGES-1];
        req_edge    = req_sync_q[SYNC_STAGES-1] ^ req_prev_q;
        dst_take    = dst_valid_q & i_dst_ready;
        dst_valid_d = dst_valid_q;
        dst_data_d  = dst_data_q;
        ack_tgl_d   = ack_tgl_q;
        // hold_q is quasi-static here: it cannot change while a request is outstanding.
        if (req_edge) begin
            dst_data_d  = hold_q;
            dst_valid_d = 1'b1;
        end else if (dst_take) begin
            dst_valid_d = 1'b0;
            ack_tgl_d   = ~ack_tgl_q;
        end
    end

    always_ff @(posedge i_dst_clk or negedge rst_n) begin
        if (!rst_n) begin
            req_sync_q  <= '0;
            req_prev_q  <= 1'b0;
            dst_valid_q <= 1'b0;
            dst_data_q  <= '0;
            ack_tgl_q   <= 1'b0;
        end else begin
            req_sync_q  <= req_sync_d;
            req_prev_q  <= req_prev_d;
            dst_valid_q <= dst_valid_d;
            dst_data_q  <= dst_data_d;
            ack_tgl_q   <= ack_tgl_d;
        end
    end

    assign o_dst_valid = dst_valid_q;
    assign o_dst_data  = dst_data_q;

`ifdef CDC_HS_XFER_CNT_EN
    logic [15:0] xfer_cnt_q, xfer_cnt_d;

    always_comb begin
        xfer_cnt_d = xfer_cnt_q;
        if (dst_take) begin
            xfer_cnt_d = xfer_cnt_q + 16'd1;
        end
    end

    always_ff @(posedge i_dst_clk or negedge rst_n) begin
        if (!rst_n) begin
            xfer_cnt_q <= 16'h0000;
        end else begin
            xfer_cnt_q <= xfer_cnt_d;
        end
    end

    assign o_dst_xfer_cnt = xfer_cnt_q;
`else
    assign o_dst_xfer_cnt = 16'h0000;
`endif

endmodule

// File: tb/tb_cdc_hs_bus_sync.sv
// Directed + randomised bench for cdc_hs_bus_sync: reference is "words delivered once, in order".
`timescale 1ns/1ps
module tb_cdc_hs_bus_sync;
    localparam int DW = 32;
    localparam int S  = 2;

    logic          src_clk = 1'b0;
    logic          dst_clk = 1'b0;
    logic          rst_n   = 1'b0;
    logic [DW-1:0] src_data = '0;
    logic          src_valid = 1'b0;
    logic          src_ready;
    logic [DW-1:0] dst_data;
    logic          dst_valid;
    logic          dst_ready = 1'b0;
    logic [15:0]   xfer_cnt;

    realtime src_half = 5.0;
    realtime dst_half = 13.5;

    int            n_chk = 0;
    int            n_fail = 0;
    logic [31:0]   rx_q[$];
    logic [31:0]   tx_q[$];
    int            valid_rises = 0;
    logic          prev_v = 1'b0;
    bit            rnd_ready = 1'b0;
    int            exp_cnt = 0;

    cdc_hs_bus_sync #(.DWIDTH(DW), .SYNC_STAGES(S)) dut (
        .i_src_clk     (src_clk),
        .i_dst_clk     (dst_clk),
        .rst_n         (rst_n),
        .i_src_data    (src_data),
        .i_src_valid   (src_valid),
        .o_src_ready   (src_ready),
        .o_dst_data    (dst_data),
        .o_dst_valid   (dst_valid),
        .i_dst_ready   (dst_ready),
        .o_dst_xfer_cnt(xfer_cnt)
    );

    initial forever #(src_half) src_clk = ~src_clk;
    initial forever #(dst_half) dst_clk = ~dst_clk;

    // Destination observer: every accepted word, and how often valid rises.
    initial forever begin
        @(negedge dst_clk);
        if (!rst_n) begin
            prev_v = 1'b0;
        end else begin
            if (dst_valid && !prev_v) valid_rises++;
            prev_v = dst_valid;
            if (dst_valid && dst_ready) begin
                rx_q.push_back(dst_data);
                exp_cnt = (exp_cnt + 1) % 65536;
            end
        end
    end

    initial forever begin
        @(negedge src_clk);
        if (rst_n && src_valid && src_ready) tx_q.push_back(src_data);
    end

    initial forever begin
        @(posedge dst_clk);
        #0.4;
        if (rnd_ready) dst_ready = ($urandom_range(0, 3) != 0);
    end

    initial begin
        #2ms;
        $display("FAIL watchdog: simulation time limit reached, observed timeout required completion");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic chk_cnt(input string tag);
        @(negedge dst_clk);
        #0.1;
`ifdef CDC_HS_XFER_CNT_EN
        chk(tag, {16'h0, xfer_cnt}, {16'h0, exp_cnt[15:0]});
`else
        chk(tag, {16'h0, xfer_cnt}, 32'h0);
`endif
    endtask

    // Waits for ready, presents one word for exactly one accepting edge.
    task automatic send(input logic [31:0] w, output bit ok);
        int n = 0;
        while (!src_ready && n < 500) begin
            @(posedge src_clk);
            #0.4;
            n++;
        end
        ok = src_ready;
        if (ok) begin
            src_valid = 1'b1;
            src_data  = w;
            @(posedge src_clk);
            #0.4;
            src_valid = 1'b0;
        end
    endtask

    task automatic wait_dst_valid(input int max_edges, output int n, output bit found);
        n = 0;
        found = 1'b0;
        while (!found && n < max_edges) begin
            @(posedge dst_clk);
            n++;
            #0.2;
            if (dst_valid) found = 1'b1;
        end
    endtask

    task automatic wait_src_ready(input int max_edges, output int n);
        n = 0;
        while (!src_ready && n < max_edges) begin
            @(posedge src_clk);
            n++;
            #0.2;
        end
    endtask

    task automatic stream256(input string tag);
        int  sent = 0;
        int  cyc = 0;
        bit  acc;
        int  m = 0;
        rx_q.delete();
        tx_q.delete();
        rnd_ready = 1'b1;
        @(posedge src_clk);
        #0.4;
        src_data  = 32'd0;
        src_valid = 1'b1;
        while (sent < 256 && cyc < 256 * 40) begin
            @(negedge src_clk);
            acc = src_ready;
            @(posedge src_clk);
            #0.4;
            cyc++;
            if (acc) begin
                sent++;
                if (sent == 256) src_valid = 1'b0;
                else src_data = 32'(sent);
            end
        end
        src_valid = 1'b0;
        chk({tag, "_sent"}, 32'(sent), 32'd256);
        while (rx_q.size() < 256 && m < 4000) begin
            @(posedge dst_clk);
            m++;
        end
        rnd_ready = 1'b0;
        #1;
        dst_ready = 1'b1;
        repeat (10) @(posedge dst_clk);
        chk({tag, "_rx_count"}, 32'(rx_q.size()), 32'd256);
        chk({tag, "_tx_count"}, 32'(tx_q.size()), 32'd256);
        for (int i = 0; i < 256 && i < rx_q.size(); i++) begin
            chk($sformatf("%s_word%0d", tag, i), rx_q[i], 32'(i));
        end
        $display("stream %s: %0d words received", tag, rx_q.size());
        chk_cnt({tag, "_xfer_cnt"});
    endtask

    initial begin
        bit ok;
        bit found;
        int n;

        // Reset sweep
        #100;
        rst_n = 1'b1;
        #1;
        chk("rst_src_ready", {31'h0, src_ready}, 32'd1);
        chk("rst_dst_valid", {31'h0, dst_valid}, 32'd0);
        chk("rst_dst_data", dst_data, 32'h0);
        chk("rst_xfer_cnt", {16'h0, xfer_cnt}, 32'h0);
        repeat (50) @(posedge src_clk);
        repeat (50) @(posedge dst_clk);
        #0.2;
        chk("idle_no_valid", 32'(valid_rises), 32'd0);
        chk("idle_src_ready", {31'h0, src_ready}, 32'd1);
        $display("reset sweep done");

        // Single word, 100 MHz -> 37 MHz, consumer always ready
        dst_ready = 1'b1;
        send(32'hA5A5_1234, ok);
        chk("single_accept", {31'h0, ok}, 32'd1);
        wait_dst_valid(S + 4, n, found);
        chk("single_valid_seen", {31'h0, found}, 32'd1);
        chk("single_valid_latency", {31'h0, n <= S + 2}, 32'd1);
        chk("single_data", dst_data, 32'hA5A5_1234);
        @(posedge dst_clk);
        #0.2;
        chk("single_pulse_1cyc", {31'h0, dst_valid}, 32'd0);
        wait_src_ready(S + 4, n);
        chk("single_ready_back", {31'h0, src_ready}, 32'd1);
        chk("single_ready_latency", {31'h0, n <= S + 2}, 32'd1);
        chk("single_rx_count", 32'(rx_q.size()), 32'd1);
        if (rx_q.size() > 0) chk("single_rx_word", rx_q[0], 32'hA5A5_1234);
        $display("single word: n=%0d rx=%0d", n, rx_q.size());

        // Destination backpressure
        dst_ready = 1'b0;
        send(32'hDEAD_BEEF, ok);
        chk("bp_accept", {31'h0, ok}, 32'd1);
        wait_dst_valid(50, n, found);
        chk("bp_valid_seen", {31'h0, found}, 32'd1);
        for (int i = 0; i < 20; i++) begin
            @(negedge dst_clk);
            chk("bp_valid_hold", {31'h0, dst_valid}, 32'd1);
            chk("bp_data_hold", dst_data, 32'hDEAD_BEEF);
            chk("bp_src_blocked", {31'h0, src_ready}, 32'd0);
        end
        @(posedge dst_clk);
        #0.4;
        dst_ready = 1'b1;
        @(posedge dst_clk);
        #0.2;
        chk("bp_valid_drop", {31'h0, dst_valid}, 32'd0);
        chk("bp_data_kept", dst_data, 32'hDEAD_BEEF);
        wait_src_ready(S + 4, n);
        chk("bp_ready_back", {31'h0, src_ready}, 32'd1);
        chk("bp_rx_count", 32'(rx_q.size()), 32'd2);
        if (rx_q.size() > 1) chk("bp_rx_word", rx_q[1], 32'hDEAD_BEEF);
        chk_cnt("bp_xfer_cnt");
        $display("backpressure: rx=%0d", rx_q.size());

        // Reset while BUSY and before the word reaches the destination
        rx_q.delete();
        send(32'h5555_AAAA, ok);
        chk("mid_accept", {31'h0, ok}, 32'd1);
        @(posedge src_clk);
        #0.4;
        chk("mid_busy", {31'h0, src_ready}, 32'd0);
        chk("mid_no_valid_yet", {31'h0, dst_valid}, 32'd0);
        rst_n = 1'b0;
        exp_cnt = 0;
        #30;
        rst_n = 1'b1;
        valid_rises = 0;
        #1;
        chk("mid_rst_ready", {31'h0, src_ready}, 32'd1);
        chk("mid_rst_valid", {31'h0, dst_valid}, 32'd0);
        chk("mid_rst_data", dst_data, 32'h0);
        repeat (50) @(posedge dst_clk);
        #0.2;
        chk("mid_no_spurious", 32'(valid_rises), 32'd0);
        chk("mid_rx_empty", 32'(rx_q.size()), 32'd0);
        send(32'h0000_0001, ok);
        chk("mid_next_accept", {31'h0, ok}, 32'd1);
        repeat (30) @(posedge dst_clk);
        #0.2;
        chk("mid_next_once", 32'(rx_q.size()), 32'd1);
        if (rx_q.size() > 0) chk("mid_next_word", rx_q[0], 32'h0000_0001);
        chk("mid_one_rise", 32'(valid_rises), 32'd1);
        chk("mid_ready_back", {31'h0, src_ready}, 32'd1);
        chk_cnt("mid_xfer_cnt");
        $display("reset mid-transfer: rx=%0d", rx_q.size());

        // Streaming at both clock ratios
        dst_half = 5.0 / 3.0;
        repeat (5) @(posedge src_clk);
        stream256("fast_dst");
        dst_half = 15.0;
        repeat (5) @(posedge src_clk);
        stream256("slow_dst");

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule

// File: doc/cdc_hs_bus_sync.md
Name: cdc_hs_bus_sync

Overview:
- Parametrised, fully handshaked bus synchroniser with 2-phase toggle request/acknowledge and a configurable synchroniser depth.
- Moves one DWIDTH-bit word at a time from i_src_clk to i_dst_clk, using valid/ready on both sides.
- Source-side backpressure: no word is lost or overwritten.
- Destination-side backpressure: a held word stays on o_dst_data until the consumer accepts it.
- Sits at every clock-domain boundary carrying low-rate control or status words.

Parameters:
- DWIDTH, 32: payload width in bits (>=1).
- SYNC_STAGES, 2: flops in each toggle synchroniser chain (>=2; values below 2 are a compile-time error).

Ports:
- i_src_clk  input  1  source clock.
- i_dst_clk  input  1  destination clock.
- rst_n  input  1  reset, asynchronous, active-low; shared by both domains.
- i_src_data  input  DWIDTH  source payload.
- i_src_valid  input  1  source word available.
- o_src_ready  output  1  block can accept a source word.
- o_dst_data  output  DWIDTH  destination payload.
- o_dst_valid  output  1  destination word available.
- i_dst_ready  input  1  destination consumer accepts the word.
- o_dst_xfer_cnt  output  16  destination transfer count (see Optional Feature).

Behaviour:
- Reset (asynchronous, both domains):
  - o_src_ready=1, o_dst_valid=0, o_dst_data=0, o_dst_xfer_cnt=0.
  - Request toggle, acknowledge toggle, all synchroniser flops and edge-detect registers=0.
  - Source FSM=IDLE.
- Source FSM (i_src_clk), states IDLE and BUSY:
  - IDLE: o_src_ready=1. On i_src_valid=1:
    - capture i_src_data into the source hold register;
    - flip the request toggle;
    - go to BUSY.
  - Same edge: o_src_ready falls.
  - BUSY: o_src_ready=0. i_src_valid and i_src_data are ignored.
  - Leave BUSY only when the synchronised acknowledge toggle (final sync stage XOR its registered copy) shows a change. Then go to IDLE, and o_src_ready=1 from the next cycle.
- Source hold register:
  - Changes only on an accepted transfer.
  - Stable for the whole BUSY interval, so it is safe to sample in the destination domain.
- Destination side (i_dst_clk):
  - The request toggle passes through SYNC_STAGES flops.
  - An edge detect (final stage XOR its registered copy) pulses for one cycle per request.
  - On the pulse: o_dst_data <= source hold register and o_dst_valid <= 1.
  - While o_dst_valid=1 and i_dst_ready=0: o_dst_data and o_dst_valid hold.
  - On o_dst_valid=1 and i_dst_ready=1:
    - o_dst_valid <= 0 at that edge;
    - the acknowledge toggle flips at that edge;
    - o_dst_data keeps its last value.
- Latency:
  - Request toggle to o_dst_valid rise: SYNC_STAGES+1 dst edges, with +1 dst edge of synchroniser uncertainty.
  - Ack flip to o_src_ready rise: SYNC_STAGES+1 src edges, with +1 src edge of uncertainty.
  - Minimum source-to-source transfer spacing = both latencies plus the destination hold time.
- Boundary conditions:
  - i_src_valid held high continuously: a new word is accepted in every IDLE cycle only. One word is in flight at a time, and there are no duplicates.
  - i_dst_ready held high: the word is consumed on the first o_dst_valid cycle (single-cycle o_dst_valid pulse).
  - i_dst_ready high while o_dst_valid=0: no effect.
  - A new request pulse cannot coincide with o_dst_valid=1, because the protocol guarantees one outstanding word.
  - Clock ratio: correct for any ratio, either clock faster.
  - rst_n asserted mid-transfer: the in-flight word is discarded and both sides return to the reset state. After release, no spurious o_dst_valid and no spurious ack, because the toggles match at 0.
- Data-path rule: only the toggle signals pass through synchroniser chains. The data bus is never synchronised bit-wise.

Optional Feature:
- Macro: CDC_HS_XFER_CNT_EN.
- Defined:
  - o_dst_xfer_cnt is a 16-bit counter in the i_dst_clk domain.
  - It increments by 1 on every o_dst_valid && i_dst_ready edge and wraps 16'hFFFF -> 16'h0000.
  - It is reset to 0 by rst_n.
- Not defined: o_dst_xfer_cnt is tied to 16'h0000 and no counter flops are built.

Test Plan:
- Reset sweep: after rst_n release, o_src_ready=1, o_dst_valid=0, o_dst_data=0. With no stimulus for 50 cycles of each clock, o_dst_valid stays 0.
- Single word, i_src_clk=100 MHz, i_dst_clk=37 MHz, i_dst_ready=1: send 32'hA5A5_1234. Expect o_dst_data=32'hA5A5_1234 with a 1-cycle o_dst_valid pulse within SYNC_STAGES+2 dst edges, then o_src_ready=1 within SYNC_STAGES+2 src edges after the ack flip.
- Destination backpressure: send 32'hDEAD_BEEF and hold i_dst_ready=0 for 20 dst cycles. Expect o_dst_valid=1 and stable data for all 20 cycles, and o_src_ready=0 throughout. Release i_dst_ready; expect one transfer and o_src_ready to return high.
- Streaming, both clock ratios (dst 3x faster and 3x slower): hold i_src_valid=1 with an incrementing payload 0..255 and random i_dst_ready. Expect 256 words received in order with no loss or duplication, and the scoreboard to match.
- Reset mid-transfer: assert rst_n while in BUSY with o_dst_valid=0, then release. Expect no o_dst_valid for 50 dst cycles; the next send of 32'h0000_0001 is delivered once.
- CDC_HS_XFER_CNT_EN defined: 65537 transfers -> o_dst_xfer_cnt=1 (wrap). Macro undefined: o_dst_xfer_cnt=0 throughout.
